led_sequencer: RTL and testbench
================================

Name: led_sequencer

Overview:
Parametrised LED pattern engine for the board's user LEDs, generalising the fixed 3-LED 1 s rotator.
- Supports N LEDs, configurable step period and output polarity.
- Four selectable modes: rotate, bounce, blink-all, breathe.
- Global PWM brightness control.
- Sits directly between the board clock/reset and the LED pins; mode, pause and brightness come from DIP switches or a future register block.

Parameters:
N_LED, 3, number of LED channels (>=1).
STEP_CYCLES, 24_000_000, sys_clk cycles per pattern step (1 s at 24 MHz); >=2.
PWM_BITS, 8, width of brightness and PWM counter.
ACTIVE_LOW, 1, 1 = LED lit when pin is 0 (board default).

Ports:
sys_clk  input  1  system clock, 24 MHz on board.
sys_rst_n  input  1  asynchronous active-low reset; all flops clear on its falling edge, release synchronous to sys_clk.
mode  input  2  00 ROTATE, 01 BOUNCE, 10 BLINK_ALL, 11 BREATHE.
pause  input  1  1 = freeze step counter and pattern; PWM keeps running.
brightness  input  PWM_BITS  duty for ROTATE/BOUNCE/BLINK_ALL.
led  output  N_LED  registered LED pins, polarity per ACTIVE_LOW.
step_pulse  output  1  one-cycle high when the pattern advances.

Behaviour:
- Reset values:
  - led = all off (all 1s if ACTIVE_LOW, else all 0s); step_pulse = 0.
  - pattern = initial pattern for mode ROTATE (bit0 lit); mode_q = 00.
  - step counter = 0; pwm counter = 0; breathe level = 0, direction up; bounce direction up.
- Step counter:
  - Counts 0..STEP_CYCLES-1 and wraps; step_tick is asserted on the cycle the counter equals STEP_CYCLES-1.
  - Counter holds while pause = 1.
  - Pattern updates on the clock edge following step_tick; step_pulse is high in that same cycle.
- Patterns (logical, 1 = lit):
  - ROTATE: one-hot rotate left, msb wraps to bit0; init 0..001.
  - BOUNCE: one-hot ping-pong, init bit0 direction up. Direction flips when the lit bit reaches msb or bit0, so ends are not repeated. N=3 sequence: 001,010,100,010,001,... N_LED=1: stays 1.
  - BLINK_ALL: init all lit; inverts every step.
  - BREATHE: pattern all lit. Triangle level 0,1,..,2^B-1,2^B-2,..,0,1,..., with no hold at endpoints. Level updates every BDIV cycles, where BDIV = max(1, STEP_CYCLES >> PWM_BITS), so one ramp lasts about one step. Level is frozen by pause.
- Mode change:
  - mode is registered into mode_q each cycle.
  - When mode != mode_q, on the next edge: pattern loads the new mode's init, step counter clears, breathe level goes to 0 (direction up), and step_pulse stays 0.
  - A mode change coincident with step_tick takes priority; no advance occurs.
- PWM:
  - Free-running PWM_BITS counter, never paused.
  - duty = breathe level in BREATHE, else brightness.
  - on = (pwm_cnt < duty) OR (duty == all ones), so max duty gives steady on and 0 gives off.
- Output: led <= (pattern & {N_LED{on}}) XOR {N_LED{ACTIVE_LOW}}. Latency is one cycle from pattern/pwm state to pins.
- Reset mid-operation: immediate return to the reset values above, regardless of state.
- All arithmetic is unsigned, width sized by $clog2 of the respective maxima; there are no overflow paths.

Decomposition:
- Package led_pkg:
  - mode enum (MODE_ROTATE, MODE_BOUNCE, MODE_BLINK_ALL, MODE_BREATHE).
  - Function init_pattern(mode, n).
  - Constant default STEP_CYCLES.
- Sub-module tick_gen: parametrised prescaler with clear and hold inputs and a single-cycle tick output. Instantiated twice: step tick and breathe tick.

Test Plan:
- Reset release, N_LED=3, STEP_CYCLES=8, brightness=all ones, mode ROTATE, ACTIVE_LOW=1:
  - led = 111 during reset, then 110 one cycle after release.
  - Steps every 8 cycles through 101, 011, 110.
  - step_pulse high exactly once per 8 cycles.
- BOUNCE, N_LED=4: logical sequence 0001,0010,0100,1000,0100,0010,0001,0010; no repeated endpoint.
- BLINK_ALL with brightness=0: led stays 111 (all off) throughout; step_pulse still pulses every 8 cycles.
- PWM_BITS=2, brightness=1, ROTATE: lit pin low 1 of every 4 cycles. brightness=3: steadily low.
- BREATHE, STEP_CYCLES=16, PWM_BITS=2 (BDIV=4): level sequence 0,1,2,3,2,1,0,1, each held 4 cycles. Pause=1 for 10 cycles freezes level and step counter.
- Mode switch ROTATE->BOUNCE on the same cycle as step_tick: no step_pulse; pattern = 001 next cycle; next advance 8 cycles later. Async reset asserted mid-step: led all off immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and helpers for the LED pattern engine.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_ROTATE    = 2'b00,
      MODE_BOUNCE    = 2'b01,
      MODE_BLINK_ALL = 2'b10,
      MODE_BREATHE   = 2'b11
   } mode_e;

   localparam int unsigned DEFAULT_STEP_CYCLES = 24_000_000;
   localparam int unsigned MAX_LED             = 32;

   // Callers keep only the low n bits of the result.
   function automatic logic [MAX_LED-1:0] init_pattern(input mode_e m, input int unsigned n);
      logic [MAX_LED-1:0] all_lit;
      all_lit = (n >= MAX_LED) ? '1 : ((MAX_LED'(1) << n) - MAX_LED'(1));
      case (m)
         MODE_BLINK_ALL, MODE_BREATHE: init_pattern = all_lit;
         default:                      init_pattern = MAX_LED'(1);
      endcase
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: one-cycle tick every PERIOD unheld cycles; clear restarts the count.
module tick_gen #(
   parameter int unsigned PERIOD = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic hold_i,
   output logic tick_o
);

   localparam int unsigned   CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (!hold_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   // A held counter must not re-fire while parked on its last value.
   assign tick_o = (cnt_q == LAST) && !hold_i;

endmodule

// File: rtl/led_sequencer.sv
// N-channel LED pattern engine: rotate/bounce/blink/breathe patterns gated by a
// global PWM, registered onto the pins with selectable polarity.
module led_sequencer
   import led_pkg::*;
#(
   parameter int unsigned N_LED       = 3,
   parameter int unsigned STEP_CYCLES = DEFAULT_STEP_CYCLES,
   parameter int unsigned PWM_BITS    = 8,
   parameter bit          ACTIVE_LOW  = 1'b1
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   input  logic [1:0]          mode,
   input  logic                pause,
   input  logic [PWM_BITS-1:0] brightness,
   output logic [N_LED-1:0]    led,
   output logic                step_pulse
);

   localparam int unsigned BDIV_RAW = STEP_CYCLES >> PWM_BITS;
   localparam int unsigned BDIV     = (BDIV_RAW > 0) ? BDIV_RAW : 1;
   localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

   mode_e               mode_in, mode_q;
   logic                mode_chg, step_tick, breathe_tick, pwm_on;
   logic                step_pulse_q, step_pulse_d;
   logic                bounce_up_q, bounce_up_d;
   logic                breathe_up_q, breathe_up_d;
   logic [N_LED-1:0]    pattern_q, pattern_d, pattern_init, led_q, led_d;
   logic [PWM_BITS-1:0] level_q, level_d, pwm_q, duty;

   assign mode_in      = mode_e'(mode);
   assign mode_chg     = (mode_in != mode_q);
   assign pattern_init = N_LED'(init_pattern(mode_in, N_LED));

   tick_gen #(.PERIOD(STEP_CYCLES)) u_step_tick (
      .clk_i(sys_clk), .rst_ni(sys_rst_n), .clear_i(mode_chg), .hold_i(pause), .tick_o(step_tick)
   );

   tick_gen #(.PERIOD(BDIV)) u_breathe_tick (
      .clk_i(sys_clk), .rst_ni(sys_rst_n), .clear_i(mode_chg), .hold_i(pause), .tick_o(breathe_tick)
   );

   // A mode change wins over a coincident step tick: reload, no advance.
   always_comb begin
      pattern_d    = pattern_q;
      bounce_up_d  = bounce_up_q;
      step_pulse_d = 1'b0;
      if (mode_chg) begin
         pattern_d   = pattern_init;
         bounce_up_d = 1'b1;
      end else if (step_tick) begin
         step_pulse_d = 1'b1;
         case (mode_q)
            MODE_ROTATE:    pattern_d = (pattern_q << 1) | (pattern_q >> (N_LED - 1));
            MODE_BOUNCE: begin
               if (N_LED > 1) begin
                  if (bounce_up_q) begin
                     pattern_d   = pattern_q << 1;
                     bounce_up_d = !pattern_d[N_LED-1];
                  end else begin
                     pattern_d   = pattern_q >> 1;
                     bounce_up_d = pattern_d[0];
                  end
               end
            end
            MODE_BLINK_ALL: pattern_d = ~pattern_q;
            default:        pattern_d = pattern_q;
         endcase
      end
   end

   // Triangle ramp turns around on the endpoint itself, so no value is held twice.
   always_comb begin
      level_d      = level_q;
      breathe_up_d = breathe_up_q;
      if (mode_chg) begin
         level_d      = '0;
         breathe_up_d = 1'b1;
      end else if (breathe_tick) begin
         if (breathe_up_q) begin
            level_d      = level_q + PWM_BITS'(1);
            breathe_up_d = (level_d != DUTY_MAX);
         end else begin
            level_d      = level_q - PWM_BITS'(1);
            breathe_up_d = (level_d == '0);
         end
      end
   end

   assign duty   = (mode_q == MODE_BREATHE) ? level_q : brightness;
   assign pwm_on = (duty == DUTY_MAX) || (pwm_q < duty);
   assign led_d  = (pattern_q & {N_LED{pwm_on}}) ^ {N_LED{ACTIVE_LOW}};

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         mode_q       <= MODE_ROTATE;
         pattern_q    <= N_LED'(1);
         bounce_up_q  <= 1'b1;
         level_q      <= '0;
         breathe_up_q <= 1'b1;
         pwm_q        <= '0;
         step_pulse_q <= 1'b0;
         led_q        <= {N_LED{ACTIVE_LOW}};
      end else begin
         mode_q       <= mode_in;
         pattern_q    <= pattern_d;
         bounce_up_q  <= bounce_up_d;
         level_q      <= level_d;
         breathe_up_q <= breathe_up_d;
         pwm_q        <= pwm_q + PWM_BITS'(1);
         step_pulse_q <= step_pulse_d;
         led_q        <= led_d;
      end
   end

   assign led        = led_q;
   assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed plus randomized bench for led_sequencer with an arithmetic reference model.
module tb_led_sequencer;

   localparam int NL   = 4;
   localparam int SC   = 16;
   localparam int PB   = 2;
   localparam int BDIV = ((SC >> PB) > 0) ? (SC >> PB) : 1;
   localparam int MAXL = (1 << PB) - 1;

   logic          sys_clk = 1'b0;
   logic          sys_rst_n = 1'b0;
   logic [1:0]    mode = 2'b00;
   logic          pause = 1'b0;
   logic [PB-1:0] brightness = '1;
   logic [NL-1:0] led;
   logic          step_pulse;

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;

   // Model state: mode_q, unpaused cycles since last clear, free-running pwm.
   int m_mode = 0;
   int m_a    = 0;
   int m_pwm  = 0;

   led_sequencer #(
      .N_LED(NL), .STEP_CYCLES(SC), .PWM_BITS(PB), .ACTIVE_LOW(1'b1)
   ) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .mode(mode), .pause(pause),
      .brightness(brightness), .led(led), .step_pulse(step_pulse)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic logic [NL-1:0] ref_pattern(input int m, input int k);
      logic [NL-1:0] one;
      int p, pos;
      one = NL'(1);
      case (m)
         0: return one << (k % NL);
         1: begin
            if (NL == 1) return one;
            p   = k % (2 * (NL - 1));
            pos = (p < NL) ? p : 2 * (NL - 1) - p;
            return one << pos;
         end
         2: return (k % 2 == 0) ? '1 : '0;
         default: return '1;
      endcase
   endfunction

   function automatic int ref_level(input int b);
      int p;
      p = b % (2 * MAXL);
      return (p <= MAXL) ? p : 2 * MAXL - p;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc_n, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0;
      m_a    = 0;
      m_pwm  = 0;
   endtask

   task automatic cyc(input logic [1:0] m, input logic p, input logic [PB-1:0] br);
      logic [NL-1:0] exp_led;
      logic          exp_pulse;
      logic          on;
      int            duty;
      @(negedge sys_clk);
      mode = m; pause = p; brightness = br;
      @(posedge sys_clk);
      cyc_n++;
      duty    = (m_mode == 3) ? ref_level(m_a / BDIV) : int'(br);
      on      = (duty == MAXL) || (m_pwm < duty);
      exp_led = (ref_pattern(m_mode, m_a / SC) & {NL{on}}) ^ {NL{1'b1}};
      exp_pulse = 1'b0;
      if (int'(m) != m_mode) begin
         m_a = 0;
      end else if (!p) begin
         exp_pulse = ((m_a % SC) == SC - 1);
         m_a++;
      end
      m_mode = int'(m);
      m_pwm  = (m_pwm + 1) % (MAXL + 1);
      #1;
      check("led", 32'(led), 32'(exp_led));
      check("step_pulse", 32'(step_pulse), 32'(exp_pulse));
   endtask

   initial begin
      int         n, pc;
      logic       got, rp;
      logic [1:0] rm;
      logic [PB-1:0] rb;

      repeat (3) @(posedge sys_clk);
      #1;
      check("reset_led", 32'(led), 32'hF);
      check("reset_pulse", 32'(step_pulse), 32'h0);
      #3 sys_rst_n = 1'b1;
      model_reset();

      cyc(2'b00, 1'b0, 2'd3);
      check("rotate_first", 32'(led), 32'hE);
      repeat (69) cyc(2'b00, 1'b0, 2'd3);
      repeat (24) cyc(2'b00, 1'b0, 2'd1);
      repeat (140) cyc(2'b01, 1'b0, 2'd3);

      pc = 0;
      for (int i = 0; i < 40; i++) begin
         cyc(2'b10, 1'b0, 2'd0);
         pc += int'(step_pulse);
      end
      check("blink_pulses", 32'(pc), 32'd2);

      repeat (60) cyc(2'b11, 1'b0, 2'd0);
      repeat (10) cyc(2'b11, 1'b1, 2'd0);
      repeat (30) cyc(2'b11, 1'b0, 2'd0);

      n = 0;
      while (n < 40 && (m_a % SC) != SC - 1) begin
         cyc(2'b00, 1'b0, 2'd3);
         n++;
      end
      cyc(2'b01, 1'b0, 2'd3);
      check("switch_no_pulse", 32'(step_pulse), 32'h0);
      n = 0;
      got = 1'b0;
      while (!got && n < 40) begin
         cyc(2'b01, 1'b0, 2'd3);
         n++;
         if (n == 1) check("switch_led", 32'(led), 32'hE);
         got = step_pulse;
      end
      check("switch_gap", 32'(n), 32'd16);

      rm = 2'b00;
      rb = 2'd3;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 49) == 0) rm = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 24) == 0) rb = 2'($urandom_range(0, 3));
         rp = ($urandom_range(0, 9) == 0);
         cyc(rm, rp, rb);
      end

      n = 0;
      got = 1'b0;
      while (!got && n < 40) begin
         cyc(2'b00, 1'b0, 2'd3);
         n++;
         got = step_pulse;
      end
      check("pre_reset_pulse", 32'(got), 32'h1);
      #2 sys_rst_n = 1'b0;
      #1;
      check("async_led", 32'(led), 32'hF);
      check("async_pulse", 32'(step_pulse), 32'h0);
      repeat (2) @(posedge sys_clk);
      #1;
      check("held_reset_led", 32'(led), 32'hF);
      #3 sys_rst_n = 1'b1;
      model_reset();
      repeat (40) cyc(2'b01, 1'b0, 2'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
